// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The fetch path and the data path share one memory port; these types
// describe the sequencer state and which requester currently owns the port.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;

   // Sequencer state: waiting for a request, counting read latency,
   // or spending the single no-grant cycle after an ack.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      ACK       = 2'd2
   } e_arb_state;

   // Owner of the memory port for the current transaction.
   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_D  = 1'b1
   } e_grant;

   // A transaction is a write only when the data path owns the port and
   // asked for a store; every fetch is a read.
   function automatic logic is_write_grant(input e_grant g, input logic we);
      return (g == GRANT_D) && we;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes and memory-port signals around the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding requesters and memory that drive it.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   // instruction-fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   // load/store requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   // shared memory port (separate read and write addresses)
   logic [ADDR_W-1:0] mem_read_addr;
   logic [DATA_W-1:0] mem_read_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_write_addr;
   logic [DATA_W-1:0] mem_write_data;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
      output if_ack, if_rdata, d_ack, d_rdata,
             mem_read_addr, mem_we, mem_write_addr, mem_write_data
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
      input  if_ack, if_rdata, d_ack, d_rdata,
             mem_read_addr, mem_we, mem_write_addr, mem_write_data
   );

endinterface

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin selector. Bit 0 of req is the fetch path, bit 1 the
// data path. On a tie the requester that did not own the port last wins.
// Purely combinational; the caller decides whether any request is present.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  e_grant     last_grant,
   output e_grant     grant
);

   // Pick the lone requester, or alternate against the previous owner on a tie
   always_comb begin
      grant = GRANT_IF;
      case (req)
         2'b01: grant = GRANT_IF;
         2'b10: grant = GRANT_D;
         2'b11: begin
            if (last_grant == GRANT_D) begin
               grant = GRANT_IF;
            end else begin
               grant = GRANT_D;
            end
         end
         default: grant = GRANT_IF;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the processor's single memory port between instruction fetch and
// load/store. One transaction is in flight at a time: a read waits
// READ_LATENCY cycles for the memory before the requester is acked, a write
// is issued and acked in the cycle right after the grant. Every output is a
// flop, so nothing combinational runs from a request to an ack or to mem_*.
// READ_LATENCY must lie in 1..15 to fit the 4-bit latency counter.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   mem_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] RL_CNT = READ_LATENCY[CNT_W-1:0];

   e_arb_state        state_q,          state_d;
   logic [CNT_W-1:0]  cnt_q,            cnt_d;
   e_grant            last_grant_q,     last_grant_d;
   e_grant            cur_grant_q,      cur_grant_d;
   logic              if_ack_q,         if_ack_d;
   logic              d_ack_q,          d_ack_d;
   logic [DATA_W-1:0] if_rdata_q,       if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,        d_rdata_d;
   logic              mem_we_q,         mem_we_d;
   logic [ADDR_W-1:0] mem_read_addr_q,  mem_read_addr_d;
   logic [ADDR_W-1:0] mem_write_addr_q, mem_write_addr_d;
   logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

   logic   any_req_s;
   e_grant grant_s;

   assign any_req_s = bus.if_req | bus.d_req;

   arb_rr2 u_rr (
      .req        ({bus.d_req, bus.if_req}),
      .last_grant (last_grant_q),
      .grant      (grant_s)
   );

   // Next-state and next-output logic: grant in IDLE, count the read
   // latency, then spend one ACK cycle with no grant before going idle
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      last_grant_d     = last_grant_q;
      cur_grant_d      = cur_grant_q;
      if_rdata_d       = if_rdata_q;
      d_rdata_d        = d_rdata_q;
      mem_read_addr_d  = mem_read_addr_q;
      mem_write_addr_d = mem_write_addr_q;
      mem_write_data_d = mem_write_data_q;
      // acks and the write strobe are single-cycle pulses
      if_ack_d         = 1'b0;
      d_ack_d          = 1'b0;
      mem_we_d         = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               last_grant_d = grant_s;
               cur_grant_d  = grant_s;
               if (is_write_grant(grant_s, bus.d_we)) begin
                  // store is issued and acknowledged in the same cycle
                  mem_we_d         = 1'b1;
                  mem_write_addr_d = bus.d_addr;
                  mem_write_data_d = bus.d_wdata;
                  d_ack_d          = 1'b1;
                  state_d          = ACK;
               end else begin
                  if (grant_s == GRANT_IF) begin
                     mem_read_addr_d = bus.if_addr;
                  end else begin
                     mem_read_addr_d = bus.d_addr;
                  end
                  cnt_d   = 4'd1;
                  state_d = READ_WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end

         READ_WAIT: begin
            if (cnt_q == RL_CNT) begin
               // memory data is valid now; hand it to whoever owns the port
               if (cur_grant_q == GRANT_IF) begin
                  if_rdata_d = bus.mem_read_data;
                  if_ack_d   = 1'b1;
               end else begin
                  d_rdata_d = bus.mem_read_data;
                  d_ack_d   = 1'b1;
               end
               state_d = ACK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ACK: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter state and all outputs; async reset drops everything at once,
   // so an in-flight transaction is forgotten and never acked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         cnt_q            <= 4'd0;
         last_grant_q     <= GRANT_D;
         cur_grant_q      <= GRANT_IF;
         if_ack_q         <= 1'b0;
         d_ack_q          <= 1'b0;
         if_rdata_q       <= 16'h0000;
         d_rdata_q        <= 16'h0000;
         mem_we_q         <= 1'b0;
         mem_read_addr_q  <= 16'h0000;
         mem_write_addr_q <= 16'h0000;
         mem_write_data_q <= 16'h0000;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         last_grant_q     <= last_grant_d;
         cur_grant_q      <= cur_grant_d;
         if_ack_q         <= if_ack_d;
         d_ack_q          <= d_ack_d;
         if_rdata_q       <= if_rdata_d;
         d_rdata_q        <= d_rdata_d;
         mem_we_q         <= mem_we_d;
         mem_read_addr_q  <= mem_read_addr_d;
         mem_write_addr_q <= mem_write_addr_d;
         mem_write_data_q <= mem_write_data_d;
      end
   end

   assign bus.if_ack         = if_ack_q;
   assign bus.d_ack          = d_ack_q;
   assign bus.if_rdata       = if_rdata_q;
   assign bus.d_rdata        = d_rdata_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_read_addr  = mem_read_addr_q;
   assign bus.mem_write_addr = mem_write_addr_q;
   assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 1 and 3) with memories
// whose read data only becomes valid the configured number of cycles after
// the read address changes. A transaction-level model predicts every output.
module tb_mem_arbiter;

   localparam int RL0 = 1;
   localparam int RL1 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if bus0 ();
   mem_arbiter_if bus1 ();

   mem_arbiter #(.READ_LATENCY(RL0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   mem_arbiter #(.READ_LATENCY(RL1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // requester inputs, one slot per instance
   logic        in_if_req   [2];
   logic [15:0] in_if_addr  [2];
   logic        in_d_req    [2];
   logic        in_d_we     [2];
   logic [15:0] in_d_addr   [2];
   logic [15:0] in_d_wdata  [2];

   // observed outputs
   logic        out_if_ack  [2];
   logic [15:0] out_if_rdata[2];
   logic        out_d_ack   [2];
   logic [15:0] out_d_rdata [2];
   logic [15:0] out_mra     [2];
   logic        out_mwe     [2];
   logic [15:0] out_mwa     [2];
   logic [15:0] out_mwd     [2];

   assign bus0.if_req  = in_if_req[0];  assign bus1.if_req  = in_if_req[1];
   assign bus0.if_addr = in_if_addr[0]; assign bus1.if_addr = in_if_addr[1];
   assign bus0.d_req   = in_d_req[0];   assign bus1.d_req   = in_d_req[1];
   assign bus0.d_we    = in_d_we[0];    assign bus1.d_we    = in_d_we[1];
   assign bus0.d_addr  = in_d_addr[0];  assign bus1.d_addr  = in_d_addr[1];
   assign bus0.d_wdata = in_d_wdata[0]; assign bus1.d_wdata = in_d_wdata[1];

   assign out_if_ack[0]   = bus0.if_ack;         assign out_if_ack[1]   = bus1.if_ack;
   assign out_if_rdata[0] = bus0.if_rdata;       assign out_if_rdata[1] = bus1.if_rdata;
   assign out_d_ack[0]    = bus0.d_ack;          assign out_d_ack[1]    = bus1.d_ack;
   assign out_d_rdata[0]  = bus0.d_rdata;        assign out_d_rdata[1]  = bus1.d_rdata;
   assign out_mra[0]      = bus0.mem_read_addr;  assign out_mra[1]      = bus1.mem_read_addr;
   assign out_mwe[0]      = bus0.mem_we;         assign out_mwe[1]      = bus1.mem_we;
   assign out_mwa[0]      = bus0.mem_write_addr; assign out_mwa[1]      = bus1.mem_write_addr;
   assign out_mwd[0]      = bus0.mem_write_data; assign out_mwd[1]      = bus1.mem_write_data;

   // default memory contents; two fixed words used by the directed reads
   function automatic logic [15:0] mem_hash(input logic [15:0] a);
      if (a == 16'h0005) return 16'h1234;
      else if (a == 16'h0100) return 16'h00AA;
      else return (a * 16'h9E37) ^ 16'hC3A5;
   endfunction

   // memories behind the two instances
   logic [15:0] bmem [2][65536];
   bit          bwr  [2][65536];
   logic [15:0] pipe1a, pipe1b;

   always @(posedge clk) begin
      if (bus0.mem_we) begin
         bmem[0][bus0.mem_write_addr] <= bus0.mem_write_data;
         bwr[0][bus0.mem_write_addr]  <= 1'b1;
      end
      if (bus1.mem_we) begin
         bmem[1][bus1.mem_write_addr] <= bus1.mem_write_data;
         bwr[1][bus1.mem_write_addr]  <= 1'b1;
      end
      pipe1a <= bus1.mem_read_addr;
      pipe1b <= pipe1a;
   end

   // latency 1: data follows the address within the cycle; latency 3: the
   // address is seen by the memory array two edges later
   assign bus0.mem_read_data = bwr[0][bus0.mem_read_addr] ? bmem[0][bus0.mem_read_addr]
                                                          : mem_hash(bus0.mem_read_addr);
   assign bus1.mem_read_data = bwr[1][pipe1b] ? bmem[1][pipe1b] : mem_hash(pipe1b);

   // ---------------- reference model ----------------
   logic [15:0] refm [2][65536];
   int          m_busy    [2];
   int          m_rd_left [2];
   bit          m_last_d  [2];
   bit          m_rd_is_d [2];
   logic [15:0] m_rd_data [2];

   logic        exp_if_ack  [2];
   logic [15:0] exp_if_rdata[2];
   logic        exp_d_ack   [2];
   logic [15:0] exp_d_rdata [2];
   logic [15:0] exp_mra     [2];
   logic        exp_mwe     [2];
   logic [15:0] exp_mwa     [2];
   logic [15:0] exp_mwd     [2];

   int checks = 0;
   int errors = 0;
   int we_seen [2];

   function automatic int rl(input int k);
      return (k == 0) ? RL0 : RL1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 0; m_rd_left[k] = 0; m_last_d[k] = 1'b1; m_rd_is_d[k] = 1'b0;
         m_rd_data[k] = 16'h0000;
         exp_if_ack[k] = 1'b0; exp_if_rdata[k] = 16'h0000;
         exp_d_ack[k] = 1'b0;  exp_d_rdata[k] = 16'h0000;
         exp_mra[k] = 16'h0000; exp_mwe[k] = 1'b0;
         exp_mwa[k] = 16'h0000; exp_mwd[k] = 16'h0000;
      end
   endtask

   // one clock edge of instance k: a free port takes a request (tie goes to
   // whoever was not served last); a busy port counts down to its ack and free time
   task automatic model_step(input int k);
      logic gi, gd;
      logic [15:0] a;
      exp_if_ack[k] = 1'b0; exp_d_ack[k] = 1'b0; exp_mwe[k] = 1'b0;
      if (m_busy[k] == 0) begin
         gi = in_if_req[k] && (!in_d_req[k] || m_last_d[k]);
         gd = in_d_req[k] && !gi;
         if (gd && in_d_we[k]) begin
            m_last_d[k] = 1'b1;
            exp_mwe[k] = 1'b1; exp_mwa[k] = in_d_addr[k]; exp_mwd[k] = in_d_wdata[k];
            exp_d_ack[k] = 1'b1;
            refm[k][in_d_addr[k]] = in_d_wdata[k];
            m_busy[k] = 1;
         end else if (gi || gd) begin
            m_last_d[k] = gd;
            a = gi ? in_if_addr[k] : in_d_addr[k];
            exp_mra[k] = a;
            m_rd_data[k] = refm[k][a];
            m_rd_is_d[k] = gd;
            m_rd_left[k] = rl(k);
            m_busy[k] = rl(k) + 1;
         end
      end else begin
         m_busy[k] = m_busy[k] - 1;
         if (m_rd_left[k] > 0) begin
            m_rd_left[k] = m_rd_left[k] - 1;
            if (m_rd_left[k] == 0) begin
               if (m_rd_is_d[k]) begin
                  exp_d_ack[k] = 1'b1; exp_d_rdata[k] = m_rd_data[k];
               end else begin
                  exp_if_ack[k] = 1'b1; exp_if_rdata[k] = m_rd_data[k];
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
      checks = checks + 1;
      assert (obs === req) else begin
         errors = errors + 1;
         $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, req);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("i%0d_if_ack", k),   16'(out_if_ack[k]), 16'(exp_if_ack[k]));
         chk($sformatf("i%0d_if_rdata", k), out_if_rdata[k],    exp_if_rdata[k]);
         chk($sformatf("i%0d_d_ack", k),    16'(out_d_ack[k]),  16'(exp_d_ack[k]));
         chk($sformatf("i%0d_d_rdata", k),  out_d_rdata[k],     exp_d_rdata[k]);
         chk($sformatf("i%0d_mem_raddr", k), out_mra[k],        exp_mra[k]);
         chk($sformatf("i%0d_mem_we", k),   16'(out_mwe[k]),    16'(exp_mwe[k]));
         chk($sformatf("i%0d_mem_waddr", k), out_mwa[k],        exp_mwa[k]);
         chk($sformatf("i%0d_mem_wdata", k), out_mwd[k],        exp_mwd[k]);
      end
   endtask

   // one clock: model advances on the edge, outputs compared on the falling edge
   task automatic cyc();
      @(posedge clk);
      if (!rst) begin
         model_step(0);
         model_step(1);
      end
      @(negedge clk);
      check_all();
      for (int k = 0; k < 2; k++) if (out_mwe[k]) we_seen[k] = we_seen[k] + 1;
   endtask

   // called just after a falling edge: reset lands mid-cycle, outputs must
   // clear before any clock edge
   task automatic rst_pulse(input int hold);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all();
      repeat (hold) cyc();
      rst = 1'b0;
   endtask

   // run clocks until the chosen ack of instance k shows; edges counts from
   // the edge that samples the request
   task automatic run_to_ack(input int k, input bit dside, output int edges);
      bit seen;
      seen = 1'b0;
      edges = 0;
      while (!seen && edges < 40) begin
         cyc();
         edges = edges + 1;
         seen = dside ? out_d_ack[k] : out_if_ack[k];
      end
      chk($sformatf("i%0d_ack_seen", k), 16'(seen), 16'd1);
   endtask

   function automatic logic [15:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return {12'h0A0, 4'($urandom_range(0, 15))};
      else return 16'($urandom);
   endfunction

   int n;
   int ord0[$];
   int ord1[$];

   initial begin
      for (int k = 0; k < 2; k++) begin
         in_if_req[k] = 1'b0; in_if_addr[k] = 16'h0000;
         in_d_req[k] = 1'b0;  in_d_we[k] = 1'b0;
         in_d_addr[k] = 16'h0000; in_d_wdata[k] = 16'h0000;
         we_seen[k] = 0;
         for (int a = 0; a < 65536; a++) refm[k][a] = mem_hash(16'(a));
      end
      model_reset();

      // power-on reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // single fetch at latency 1
      in_if_req[0] = 1'b1; in_if_addr[0] = 16'h0005;
      run_to_ack(0, 1'b0, n);
      chk("fetch_latency", 16'(n), 16'd2);
      chk("fetch_rdata", out_if_rdata[0], 16'h1234);
      chk("fetch_raddr", out_mra[0], 16'h0005);
      chk("fetch_no_dack", 16'(out_d_ack[0]), 16'd0);
      in_if_req[0] = 1'b0;
      cyc();
      chk("fetch_ack_pulse", 16'(out_if_ack[0]), 16'd0);

      // store
      in_d_req[0] = 1'b1; in_d_we[0] = 1'b1; in_d_addr[0] = 16'h0040; in_d_wdata[0] = 16'hBEEF;
      we_seen[0] = 0;
      cyc();
      chk("wr_we", 16'(out_mwe[0]), 16'd1);
      chk("wr_addr", out_mwa[0], 16'h0040);
      chk("wr_data", out_mwd[0], 16'hBEEF);
      chk("wr_ack", 16'(out_d_ack[0]), 16'd1);
      in_d_req[0] = 1'b0;
      repeat (2) cyc();
      chk("wr_we_once", 16'(we_seen[0]), 16'd1);

      // load back the stored word
      in_d_req[0] = 1'b1; in_d_we[0] = 1'b0; in_d_addr[0] = 16'h0040;
      run_to_ack(0, 1'b1, n);
      chk("rdback_latency", 16'(n), 16'd2);
      chk("rdback_data", out_d_rdata[0], 16'hBEEF);
      in_d_req[0] = 1'b0;
      cyc();

      // data read at latency 3
      in_d_req[1] = 1'b1; in_d_we[1] = 1'b0; in_d_addr[1] = 16'h0100;
      we_seen[1] = 0;
      run_to_ack(1, 1'b1, n);
      chk("rl3_latency", 16'(n), 16'd4);
      chk("rl3_rdata", out_d_rdata[1], 16'h00AA);
      in_d_req[1] = 1'b0;
      cyc();
      chk("rl3_no_we", 16'(we_seen[1]), 16'd0);

      // tie from reset: both requesters held on both instances
      for (int k = 0; k < 2; k++) begin
         in_if_req[k] = 1'b1; in_if_addr[k] = 16'h0010;
         in_d_req[k] = 1'b1; in_d_we[k] = 1'b0; in_d_addr[k] = 16'h0020;
      end
      rst_pulse(1);
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (out_if_ack[0]) ord0.push_back(0);
         if (out_d_ack[0])  ord0.push_back(1);
         if (out_if_ack[1]) ord1.push_back(0);
         if (out_d_ack[1])  ord1.push_back(1);
      end
      chk("rr_count0", 16'(ord0.size() >= 4), 16'd1);
      chk("rr_count1", 16'(ord1.size() >= 4), 16'd1);
      for (int i = 0; i < 4 && i < ord0.size(); i++) chk($sformatf("rr_order0_%0d", i), 16'(ord0[i]), 16'(i % 2));
      for (int i = 0; i < 4 && i < ord1.size(); i++) chk($sformatf("rr_order1_%0d", i), 16'(ord1[i]), 16'(i % 2));
      for (int k = 0; k < 2; k++) begin
         in_if_req[k] = 1'b0; in_d_req[k] = 1'b0;
      end
      rst_pulse(1);

      // reset one cycle after a latency-3 grant; the held fetch restarts
      in_if_req[1] = 1'b1; in_if_addr[1] = 16'h0005;
      cyc();
      cyc();
      rst_pulse(2);
      chk("rst_no_ack", 16'(out_if_ack[1]), 16'd0);
      run_to_ack(1, 1'b0, n);
      chk("rst_restart_latency", 16'(n), 16'd4);
      chk("rst_restart_rdata", out_if_rdata[1], 16'h1234);
      in_if_req[1] = 1'b0;
      cyc();

      // randomized traffic; requesters keep request and payload until acked
      for (int c = 0; c < 700; c++) begin
         if (c == 350) rst_pulse(1);
         for (int k = 0; k < 2; k++) begin
            if (out_if_ack[k] || !in_if_req[k]) begin
               in_if_req[k] = ($urandom_range(0, 2) != 0);
               in_if_addr[k] = rand_addr();
            end
            if (out_d_ack[k] || !in_d_req[k]) begin
               in_d_req[k] = ($urandom_range(0, 2) != 0);
               in_d_we[k] = ($urandom_range(0, 2) == 0);
               in_d_addr[k] = rand_addr();
               in_d_wdata[k] = 16'($urandom);
            end
         end
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the processor's single memory port between the instruction-fetch path and the data (load/store) path. It accepts one request at a time from each requester over a req/ack handshake and grants round-robin when both are pending. It sequences the read-wait for a memory of fixed read latency and drives the memory's separate read/write address, write-data and write-enable signals.

## Interface
- READ_LATENCY, default 1: cycles from mem_read_addr change to mem_read_data valid; legal range 1..15.
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- if_req  input  1  fetch request; held with if_addr until if_ack
- if_addr  input  16  fetch address
- if_ack  output  1  one-cycle pulse; if_rdata valid while high
- if_rdata  output  16  fetched word, held until next fetch ack
- d_req  input  1  data request; held with d_we/d_addr/d_wdata until d_ack
- d_we  input  1  1 = write, 0 = read
- d_addr  input  16  data address
- d_wdata  input  16  write data
- d_ack  output  1  one-cycle completion pulse
- d_rdata  output  16  load data, held until next data read ack
- mem_read_addr  output  16  memory read address
- mem_read_data  input  16  memory read data
- mem_we  output  1  memory write strobe
- mem_write_addr  output  16  memory write address
- mem_write_data  output  16  memory write data

## Operation
- States: IDLE, READ_WAIT, ACK.
- IDLE: if neither req is high, stay. If exactly one is high, grant it. If both are high, grant the requester that was not granted last. After reset, last_grant = DATA, so fetch wins the first tie.
- Grant of a read (fetch, or data with d_we=0): register mem_read_addr <= address; cnt <= 1; go to READ_WAIT.
- READ_WAIT: if cnt == READ_LATENCY, capture mem_read_data into the granted rdata register, pulse the granted ack, and go to ACK. Otherwise cnt <= cnt+1.
- Grant of a write: in the same edge, set mem_we <= 1, mem_write_addr <= d_addr, mem_write_data <= d_wdata and d_ack <= 1; go to ACK.
- ACK: lasts one cycle, with no grant. mem_we and ack return to 0; go to IDLE.
  - A req still high in IDLE is a new transaction.
- Requests are sampled only at grant. Dropping or changing req/payload after grant does not abort: the transaction completes and the ack is still issued.
- The ungranted requester waits; its ack stays 0.
- cnt width: 4 bits. Address and data pass through unmodified; no arithmetic on addresses.
- mem_read_addr holds its last value outside reads. mem_write_addr/mem_write_data hold their last values. mem_we is high only in the write-grant cycle.

## Timing
- Reset values: if_ack=0, d_ack=0, if_rdata=0, d_rdata=0, mem_we=0, mem_read_addr=0, mem_write_addr=0, mem_write_data=0, state=IDLE, cnt=0, last_grant=DATA.
- Read: req sampled at edge E0. mem_read_addr is valid after E0. Data is captured at edge E0+READ_LATENCY. Ack is high during the cycle after E0+READ_LATENCY. Req-to-ack is READ_LATENCY+1 cycles; read throughput is one per READ_LATENCY+2 cycles.
- Write: req sampled at E0. mem_we and d_ack are both high in the cycle after E0; one write per 2 cycles.
- Reset mid-transaction: all outputs clear immediately. The pending ack is never issued. After release, a held req is treated as a new request.
- All outputs are registered; there is no combinational path from req to ack or to mem_*.

## Structure
- Package mem_arb_pkg: e_arb_state enum (IDLE, READ_WAIT, ACK) and e_grant enum (GRANT_IF, GRANT_D).
- Sub-module arb_rr2: inputs req[1:0] and last_grant; output is the selected grant. It is combinational, two-way round-robin, and is instantiated once.

## Test plan
- Reset: assert rst mid-simulation -> every output reads 0 within the same cycle, without a clock edge.
- Single fetch, READ_LATENCY=1: if_addr=0x0005, memory returns 0x1234 -> mem_read_addr=0x0005 after E0; if_ack is high exactly 2 cycles after req is sampled; if_rdata=0x1234; d_ack stays 0.
- Tie and round-robin: if_req and d_req (read, 0x0020) both held from reset -> grant order is fetch, data, fetch, data over 4 transactions; each ack pulses exactly once per transaction.
- Write: d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> mem_we is high for exactly one cycle with mem_write_addr=0x0040 and mem_write_data=0xBEEF; d_ack is high in that same cycle.
- Reset during READ_WAIT (READ_LATENCY=3): assert rst one cycle after grant -> no ack follows; after release, a held req completes normally with correct data.
- READ_LATENCY=3 data read at 0x0100, returning 0x00AA -> d_ack arrives 4 cycles after req is sampled; d_rdata=0x00AA; mem_we stays 0 throughout.
